// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory responder.
//   - RISC-V load/store funct3 size codes
//   - responder FSM state encoding
//   - latched request record
//   - helpers that classify illegal sizes and misaligned addresses
package mem_pkg;

  // funct3 size codes as issued by the MEM stage
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // responder FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // low address bits that must be zero for each access width
  localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // request as captured at acceptance
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Reserved funct3 codes are always illegal; the unsigned variants only
  // make sense for loads, so a store using them is illegal as well.
  function automatic logic isIllegalSize(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

  // Bytes are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    case (funct3)
      F3_H, F3_HU: return (addrLo & HALF_ALIGN_MASK) != 2'b00;
      F3_W:        return (addrLo & WORD_ALIGN_MASK) != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the responder.
//   i_addr_lo    : byte offset within the word (addr[1:0])
//   i_funct3     : RISC-V size code
//   i_wdata      : right-aligned store data
//   i_old_word   : current contents of the addressed word
//   o_store_word : old word with the selected lanes replaced by store data
//   o_load_data  : selected lane(s) sign/zero extended to 32 bits
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old_word,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data
);

  logic [4:0]  w_bit_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // byte lane n lives at bit 8n; the half is chosen by addr[1]
  assign w_bit_off = {i_addr_lo, 3'b000};
  assign w_byte    = i_old_word[w_bit_off +: 8];
  assign w_half    = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];

  // load extraction: pick the lane, then extend by size code
  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      F3_W:    o_load_data = i_old_word;
      default: o_load_data = '0;
    endcase
  end

  // store merge: unselected lanes keep their previous value
  always_comb begin
    o_store_word = i_old_word;
    case (i_funct3)
      F3_B: o_store_word[w_bit_off +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_store_word = i_wdata;
      default: o_store_word = i_old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder for the MEM
// stage, with a valid/ready request channel and a valid/ready response
// channel and a fixed access latency.
//   clock, reset              : clock and synchronous active-high reset
//   req_valid / req_ready     : request handshake
//   req_write, req_funct3     : store/load and RISC-V size code
//   req_addr, req_wdata       : byte address and right-aligned store data
//   resp_valid / resp_ready   : response handshake
//   resp_rdata                : extended load data (0 for stores/errors)
//   resp_error                : illegal size, misaligned or out-of-range
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]  r_state;
  logic [3:0]  r_count;
  mem_req_t    r_req;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic             w_out_of_range;
  logic             w_error;
  logic             w_commit;
  logic [31:0]      w_old_word;
  logic [31:0]      w_store_word;
  logic [31:0]      w_load_data;

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

  // All fault checks look at the latched request, never the live inputs.
  assign w_idx          = r_req.addr[IDX_W+1:2];
  assign w_out_of_range = (r_req.addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_error        = isIllegalSize(r_req.write, r_req.funct3)
                        | isMisaligned(r_req.funct3, r_req.addr[1:0])
                        | w_out_of_range;
  assign w_old_word     = w_out_of_range ? 32'd0 : r_mem[w_idx];

  // The commit edge is the one leaving WAIT with the counter exhausted.
  assign w_commit = (r_state == ST_WAIT) && (r_count == 4'd0);

  lsu_lane_align u_align (
    .i_addr_lo    (r_req.addr[1:0]),
    .i_funct3     (r_req.funct3),
    .i_wdata      (r_req.wdata),
    .i_old_word   (w_old_word),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data)
  );

  // Control FSM. Every accepted request passes through WAIT so that the
  // commit always uses registered request fields; the counter starts at
  // LATENCY-1, which puts resp_valid exactly LATENCY edges after acceptance
  // (for LATENCY=1, WAIT lasts a single cycle with the counter already 0).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_req   <= '0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req   <= '{write: req_write, funct3: req_funct3,
                         addr: req_addr, wdata: req_wdata};
            r_count <= 4'(LATENCY - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= ST_RESP;
            r_error <= w_error;
            r_rdata <= (w_error || r_req.write) ? 32'd0 : w_load_data;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the
  // write so a discarded transaction leaves memory untouched.
  always_ff @(posedge clock) begin
    if (!reset && w_commit && r_req.write && !w_error) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed, table-driven bench. A LATENCY=1 instance
// runs the vector table; a LATENCY=4 instance covers stalls, back-to-back
// acceptance and reset during WAIT.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clock;
  logic        reset;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic        fReqValid, fReqReady, fRespValid, fRespReady, fRespError;
  logic [31:0] fRespRdata;
  logic        sReqValid, sReqReady, sRespValid, sRespReady, sRespError;
  logic [31:0] sRespRdata;

  logic        useSlow;
  logic        mReqReady, mRespValid, mRespError;
  logic [31:0] mRespRdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dutFast (
    .clock(clock), .reset(reset),
    .req_valid(fReqValid), .req_ready(fReqReady), .req_write(reqWrite),
    .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(fRespValid), .resp_ready(fRespReady),
    .resp_rdata(fRespRdata), .resp_error(fRespError)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dutSlow (
    .clock(clock), .reset(reset),
    .req_valid(sReqValid), .req_ready(sReqReady), .req_write(reqWrite),
    .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(sRespValid), .resp_ready(sRespReady),
    .resp_rdata(sRespRdata), .resp_error(sRespError)
  );

  assign mReqReady  = useSlow ? sReqReady  : fReqReady;
  assign mRespValid = useSlow ? sRespValid : fRespValid;
  assign mRespError = useSlow ? sRespError : fRespError;
  assign mRespRdata = useSlow ? sRespRdata : fRespRdata;

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setValid(input bit slow, input logic v);
    if (slow) sReqValid = v;
    else      fReqValid = v;
  endtask

  task automatic setReady(input bit slow, input logic v);
    if (slow) sRespReady = v;
    else      fRespReady = v;
  endtask

  task automatic addVec(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expRdata, input logic expErr);
    vec_t v;
    v.name = name; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // One complete transaction: present, accept, count edges to resp_valid
  // (bounded), capture the response, then handshake it away.
  task automatic applyStimulus(input bit slow, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    useSlow = slow;
    @(negedge clock);
    checkOutput("req_ready idle", {31'd0, mReqReady}, 32'd1);
    reqWrite = wr; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
    setValid(slow, 1'b1);
    @(posedge clock);
    #1 setValid(slow, 1'b0);
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!mRespValid && lat < 40);
    rdata = mRespRdata;
    err   = mRespError;
    setReady(slow, 1'b1);
    @(posedge clock);
    #1 setReady(slow, 1'b0);
    checkOutput("resp_valid after handshake", {31'd0, mRespValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    reset = 1'b1; useSlow = 1'b0;
    fReqValid = 1'b0; fRespReady = 1'b0; sReqValid = 1'b0; sRespReady = 1'b0;
    reqWrite = 1'b0; reqFunct3 = F3_W; reqAddr = '0; reqWdata = '0;

    addVec("sw 0x10",        1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0);
    addVec("lw 0x10",        1'b0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
    addVec("lb 0x13",        1'b0, F3_B,   32'h13,   32'h0,        32'hFFFFFFDE, 1'b0);
    addVec("lbu 0x13",       1'b0, F3_BU,  32'h13,   32'h0,        32'h000000DE, 1'b0);
    addVec("lh 0x12",        1'b0, F3_H,   32'h12,   32'h0,        32'hFFFFDEAD, 1'b0);
    addVec("lhu 0x10",       1'b0, F3_HU,  32'h10,   32'h0,        32'h0000BEEF, 1'b0);
    addVec("sb 0x11",        1'b1, F3_B,   32'h11,   32'hFFFFFF55, 32'h00000000, 1'b0);
    addVec("lw after sb",    1'b0, F3_W,   32'h10,   32'h0,        32'hDEAD55EF, 1'b0);
    addVec("sh 0x12",        1'b1, F3_H,   32'h12,   32'hABCD1234, 32'h00000000, 1'b0);
    addVec("lw after sh",    1'b0, F3_W,   32'h10,   32'h0,        32'h123455EF, 1'b0);
    addVec("lw misaligned",  1'b0, F3_W,   32'h12,   32'h0,        32'h00000000, 1'b1);
    addVec("lh misaligned",  1'b0, F3_H,   32'h11,   32'h0,        32'h00000000, 1'b1);
    addVec("sw out of range",1'b1, F3_W,   32'h1000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    addVec("store f3=011",   1'b1, 3'b011, 32'h10,   32'h0,        32'h00000000, 1'b1);
    addVec("store as bu",    1'b1, F3_BU,  32'h10,   32'h0,        32'h00000000, 1'b1);
    addVec("lw f3=111",      1'b0, 3'b111, 32'h10,   32'h0,        32'h00000000, 1'b1);
    addVec("lw unchanged",   1'b0, F3_W,   32'h10,   32'h0,        32'h123455EF, 1'b0);
    addVec("lb positive",    1'b0, F3_B,   32'h11,   32'h0,        32'h00000055, 1'b0);
    addVec("lh positive",    1'b0, F3_H,   32'h10,   32'h0,        32'h000055EF, 1'b0);
    addVec("sw last word",   1'b1, F3_W,   32'hFFC,  32'h80000001, 32'h00000000, 1'b0);
    addVec("lw last word",   1'b0, F3_W,   32'hFFC,  32'h0,        32'h80000001, 1'b0);
    addVec("lhu 0xffe",      1'b0, F3_HU,  32'hFFE,  32'h0,        32'h00008000, 1'b0);
    addVec("lh 0xffe",       1'b0, F3_H,   32'hFFE,  32'h0,        32'hFFFF8000, 1'b0);
    addVec("lb 0xffc",       1'b0, F3_B,   32'hFFC,  32'h0,        32'h00000001, 1'b0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    checkOutput("reset fast req_ready",  {31'd0, fReqReady},  32'd1);
    checkOutput("reset fast resp_valid", {31'd0, fRespValid}, 32'd0);
    checkOutput("reset fast resp_rdata", fRespRdata,          32'd0);
    checkOutput("reset fast resp_error", {31'd0, fRespError}, 32'd0);
    checkOutput("reset slow req_ready",  {31'd0, sReqReady},  32'd1);
    checkOutput("reset slow resp_valid", {31'd0, sRespValid}, 32'd0);

    // vector table on the LATENCY=1 instance
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      checkOutput({vecs[i].name, " rdata"},   rd,               vecs[i].expRdata);
      checkOutput({vecs[i].name, " error"},   {31'd0, er},      {31'd0, vecs[i].expErr});
      checkOutput({vecs[i].name, " latency"}, 32'(lat),         32'd1);
    end

    // LATENCY=4: store, then a stalled load with a queued follow-up request
    applyStimulus(1'b1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, rd, er, lat);
    checkOutput("slow sw latency", 32'(lat), 32'd4);
    checkOutput("slow sw error",   {31'd0, er}, 32'd0);

    useSlow = 1'b1;
    @(negedge clock);
    reqWrite = 1'b0; reqFunct3 = F3_W; reqAddr = 32'h40;
    sReqValid = 1'b1;
    @(posedge clock);
    #1 sReqValid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      checkOutput("slow lw req_ready busy", {31'd0, sReqReady}, 32'd0);
      if (i < 4) checkOutput("slow lw early valid", {31'd0, sRespValid}, 32'd0);
    end
    checkOutput("slow lw valid at 4", {31'd0, sRespValid}, 32'd1);
    checkOutput("slow lw rdata",      sRespRdata,          32'hCAFEF00D);

    reqFunct3 = F3_BU;
    sReqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("stall resp_valid", {31'd0, sRespValid}, 32'd1);
      checkOutput("stall rdata",      sRespRdata,          32'hCAFEF00D);
      checkOutput("stall req_ready",  {31'd0, sReqReady},  32'd0);
    end
    sRespReady = 1'b1;
    @(posedge clock);
    #1 sRespReady = 1'b0;
    checkOutput("post handshake valid",     {31'd0, sRespValid}, 32'd0);
    checkOutput("post handshake rdata",     sRespRdata,          32'd0);
    checkOutput("post handshake req_ready", {31'd0, sReqReady},  32'd1);
    @(posedge clock);
    #1 sReqValid = 1'b0;
    checkOutput("queued req accepted", {31'd0, sReqReady}, 32'd0);
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!sRespValid && lat < 40);
    checkOutput("queued lbu latency", 32'(lat),          32'd4);
    checkOutput("queued lbu rdata",   sRespRdata,        32'h0000000D);
    checkOutput("queued lbu error",   {31'd0, sRespError}, 32'd0);
    sRespReady = 1'b1;
    @(posedge clock);
    #1 sRespReady = 1'b0;

    // reset during WAIT discards the pending store
    applyStimulus(1'b1, 1'b1, F3_W, 32'h20, 32'h00000000, rd, er, lat);
    @(negedge clock);
    reqWrite = 1'b1; reqFunct3 = F3_W; reqAddr = 32'h20; reqWdata = 32'hA5A5A5A5;
    sReqValid = 1'b1;
    @(posedge clock);
    #1 sReqValid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("wait reset req_ready",  {31'd0, sReqReady},  32'd1);
    checkOutput("wait reset resp_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("wait reset resp_rdata", sRespRdata,          32'd0);
    checkOutput("wait reset resp_error", {31'd0, sRespError}, 32'd0);
    repeat (6) @(posedge clock);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
    checkOutput("lw 0x20 after reset", rd, 32'h00000000);
    applyStimulus(1'b0, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    checkOutput("fast mem retained", rd, 32'h123455EF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
